// File: rtl/interrupt_controller_pkg.sv
// Shared types and codes for the interrupt controller.
// States, mode codes, vector/done prefixes and table helpers.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    CFG,
    PRI_LOAD,
    ARB,
    WAIT_ACK,
    DRIVE,
    WAIT_DONE
  } state_e;

  localparam logic [1:0] MODE_POLL = 2'b01;
  localparam logic [1:0] MODE_PRI  = 2'b10;

  localparam logic [4:0] VEC_POLL  = 5'b01011;
  localparam logic [4:0] VEC_PRI   = 5'b10011;
  localparam logic [4:0] DONE_POLL = 5'b10100;
  localparam logic [4:0] DONE_PRI  = 5'b01100;

  // Entry r holds the source id that owns rank r.
  typedef logic [7:0][2:0] pri_tbl_t;

  function automatic logic [7:0] vector_of(
    input logic       pri,
    input logic [2:0] id
  );
    return {(pri ? VEC_PRI : VEC_POLL), id};
  endfunction

  function automatic logic [7:0] done_of(
    input logic       pri,
    input logic [2:0] id
  );
    return {(pri ? DONE_PRI : DONE_POLL), id};
  endfunction

  function automatic pri_tbl_t tbl_load(
    input pri_tbl_t   t,
    input logic [1:0] k,
    input logic [7:0] b
  );
    pri_tbl_t r;
    r = t;
    r[{k, 1'b0}] = b[7:5];
    r[{k, 1'b1}] = b[4:2];
    return r;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/strobe/interrupt handshake between sources, CPU and controller.
// slave = controller side, master = processor/source side.
interface interrupt_controller_if;

  logic [7:0] intr_rq;
  logic       intr_in;
  logic       intr_out;
  logic       bus_oe;

  modport slave (
    input  intr_rq,
    input  intr_in,
    output intr_out,
    output bus_oe
  );

  modport master (
    output intr_rq,
    output intr_in,
    input  intr_out,
    input  bus_oe
  );

endinterface

// File: rtl/interrupt_controller_arbiter.sv
// Combinational winner selection: round-robin from a pointer,
// or lowest rank from the priority table.
module intr_arbiter
  import interrupt_controller_pkg::*;
(
  input  logic [7:0] req_i,
  input  logic       pri_i,
  input  logic [2:0] ptr_i,
  input  pri_tbl_t   tbl_i,
  output logic [2:0] id_o,
  output logic       valid_o
);

  logic [2:0] rr_id;
  logic       rr_hit;
  logic [2:0] pr_id;
  logic       pr_hit;
  logic [2:0] idx;

  // Scan downward so the nearest/lowest match is written last.
  always_comb begin
    rr_id  = ptr_i;
    rr_hit = 1'b0;
    idx    = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_i + 3'(k);
      if (req_i[idx]) begin
        rr_id  = idx;
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    pr_id  = '0;
    pr_hit = 1'b0;
    for (int r = 7; r >= 0; r--) begin
      if (req_i[tbl_i[r]]) begin
        pr_id  = tbl_i[r];
        pr_hit = 1'b1;
      end
    end
  end

  assign id_o    = pri_i ? pr_id  : rr_id;
  assign valid_o = pri_i ? pr_hit : rr_hit;

endmodule

// File: rtl/interrupt_controller.sv
// 8-source interrupt controller, polling or ranked priority, vectored ack.
// Define INTR_DONE_CHECK_EN to require a matching done code on the bus.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  inout  wire  [7:0]             intr_bus,
  interrupt_controller_if.slave  irq
);

  state_e     state_q, state_d;
  logic       pri_q, pri_d;
  logic [1:0] cnt_q, cnt_d;
  pri_tbl_t   tbl_q, tbl_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] id_q, id_d;
  logic       out_q, out_d;
  logic       oe_q, oe_d;

  logic       strobe;
  logic [7:0] bus_in;
  logic [2:0] arb_id;
  logic       arb_valid;
  logic       done_ok;

  assign strobe = ~irq.intr_in;
  assign bus_in = intr_bus;

  intr_arbiter u_arb (
    .req_i   (irq.intr_rq),
    .pri_i   (pri_q),
    .ptr_i   (ptr_q),
    .tbl_i   (tbl_q),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

`ifdef INTR_DONE_CHECK_EN
  assign done_ok = (bus_in == done_of(pri_q, id_q));
`else
  assign done_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    out_d   = out_q;
    oe_d    = oe_q;
    unique case (state_q)
      CFG: begin
        if (bus_in[1:0] == MODE_POLL) begin
          pri_d   = 1'b0;
          state_d = ARB;
        end else if (bus_in[1:0] == MODE_PRI) begin
          pri_d   = 1'b1;
          tbl_d   = tbl_load(tbl_q, 2'd0, bus_in);
          cnt_d   = 2'd1;
          state_d = PRI_LOAD;
        end
      end
      PRI_LOAD: begin
        tbl_d = tbl_load(tbl_q, cnt_q, bus_in);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (arb_valid) begin
          id_d    = arb_id;
          out_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (strobe) begin
          out_d   = 1'b0;
          oe_d    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (strobe) begin
          oe_d    = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Pointer keeps last serviced + 1, where the next poll starts.
        if (strobe && done_ok) begin
          ptr_d   = id_q + 3'd1;
          state_d = ARB;
        end
      end
      default: begin
        state_d = CFG;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= CFG;
      pri_q   <= 1'b0;
      cnt_q   <= '0;
      tbl_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign irq.intr_out = out_q;
  assign irq.bus_oe   = oe_q;
  assign intr_bus     = oe_q ? vector_of(pri_q, id_q) : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: spec-level model checked every cycle
// plus literal service orders and handshake checks.
module tb_interrupt_controller;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] cpu_bus;
  wire  [7:0] intr_bus;

  interrupt_controller_if irq_if();

  assign intr_bus = irq_if.bus_oe ? 8'hzz : cpu_bus;

  interrupt_controller dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .intr_bus (intr_bus),
    .irq      (irq_if)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int S_CFG  = 0;
  localparam int S_LOAD = 1;
  localparam int S_IDLE = 2;
  localparam int S_RAIS = 3;
  localparam int S_DRV  = 4;
  localparam int S_DONE = 5;

  int         m_st  = S_CFG;
  bit         m_pri = 1'b0;
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [2:0] m_id  = '0;
  logic [2:0] m_ord [8];
  int         m_served [$];

  function automatic bit pick(input logic [7:0] rq, output logic [2:0] w);
    w = '0;
    if (m_pri) begin
      for (int r = 0; r < 8; r++)
        if (rq[m_ord[r]]) begin
          w = m_ord[r];
          return 1'b1;
        end
    end else begin
      for (int k = 0; k < 8; k++) begin
        w = 3'((m_ptr + k) % 8);
        if (rq[w]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk_in) begin : model
    logic [7:0] b;
    logic [2:0] w;
    bit         stb;
    bit         ok;
    b   = intr_bus;
    stb = (irq_if.intr_in == 1'b0);
    if (rst_in) begin
      m_st  = S_CFG;
      m_pri = 1'b0;
      m_ptr = 0;
      m_id  = '0;
      for (int r = 0; r < 8; r++) m_ord[r] = '0;
    end else if (m_st == S_CFG) begin
      if (b[1:0] == 2'b01) begin
        m_pri = 1'b0;
        m_st  = S_IDLE;
      end else if (b[1:0] == 2'b10) begin
        m_pri = 1'b1;
        m_ord[0] = b[7:5];
        m_ord[1] = b[4:2];
        m_cnt = 1;
        m_st  = S_LOAD;
      end
    end else if (m_st == S_LOAD) begin
      m_ord[2*m_cnt]   = b[7:5];
      m_ord[2*m_cnt+1] = b[4:2];
      m_cnt++;
      if (m_cnt == 4) m_st = S_IDLE;
    end else if (m_st == S_IDLE) begin
      if (pick(irq_if.intr_rq, w)) begin
        m_id = w;
        m_st = S_RAIS;
      end
    end else if (m_st == S_RAIS) begin
      if (stb) m_st = S_DRV;
    end else if (m_st == S_DRV) begin
      if (stb) m_st = S_DONE;
    end else if (m_st == S_DONE) begin
`ifdef INTR_DONE_CHECK_EN
      ok = (b == {(m_pri ? 5'b01100 : 5'b10100), m_id});
`else
      ok = 1'b1;
`endif
      if (stb && ok) begin
        m_served.push_back(int'(m_id));
        m_ptr = (int'(m_id) + 1) % 8;
        m_st  = S_IDLE;
      end
    end
  end

  always @(negedge clk_in) begin
    if (run_cmp) begin
      check("cyc_intr_out", 32'(irq_if.intr_out), 32'(m_st == S_RAIS));
      check("cyc_bus_oe", 32'(irq_if.bus_oe), 32'(m_st == S_DRV));
      if (m_st == S_DRV)
        check("cyc_vector", 32'(intr_bus),
              32'({(m_pri ? 5'b10011 : 5'b01011), m_id}));
    end
  end

  // ---------------- stimulus ----------------
  int got_ids [$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic strobe();
    irq_if.intr_in = 1'b0;
    @(negedge clk_in);
    irq_if.intr_in = 1'b1;
  endtask

  task automatic wait_irq(output bit ok);
    int n;
    n = 0;
    while (irq_if.intr_out !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    ok = (irq_if.intr_out === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL irq_timeout: intr_out stayed %b want 1", irq_if.intr_out);
    end
  endtask

  task automatic service(input logic [2:0] eid, input logic [4:0] vpre,
                         input logic [4:0] dpre, input bit bad_done,
                         input logic [7:0] clr);
    bit ok;
    logic [7:0] v;
    wait_irq(ok);
    if (!ok) return;
    irq_if.intr_rq = irq_if.intr_rq & ~clr;
    strobe();
    check("ack_intr_out", 32'(irq_if.intr_out), 32'd0);
    check("ack_bus_oe", 32'(irq_if.bus_oe), 32'd1);
    v = intr_bus;
    check("vector", 32'(v), 32'({vpre, eid}));
    tick(1);
    check("vector_hold", 32'(intr_bus), 32'({vpre, eid}));
    strobe();
    check("release_oe", 32'(irq_if.bus_oe), 32'd0);
    if (bad_done) begin
      cpu_bus = {dpre, 3'd0};
      strobe();
      cpu_bus = 8'h00;
`ifdef INTR_DONE_CHECK_EN
      tick(4);
      check("bad_done_no_irq", 32'(irq_if.intr_out), 32'd0);
      cpu_bus = {dpre, eid};
      strobe();
`endif
    end else begin
      cpu_bus = {dpre, eid};
      strobe();
    end
    cpu_bus = 8'h00;
    got_ids.push_back(int'(v[2:0]));
  endtask

  int exp_poll [8] = '{1, 3, 5, 7, 0, 2, 4, 6};
  int exp_pri [10] = '{5, 3, 7, 0, 4, 3, 2, 5, 6, 1};

  initial begin
    bit ok;
    logic [7:0] m;
    rst_in         = 1'b1;
    cpu_bus        = 8'h00;
    irq_if.intr_rq = 8'h00;
    irq_if.intr_in = 1'b1;
    tick(2);
    rst_in  = 1'b0;
    run_cmp = 1'b1;
    check("rst_intr_out", 32'(irq_if.intr_out), 32'd0);
    check("rst_bus_oe", 32'(irq_if.bus_oe), 32'd0);

    // unconfigured: requests and strobes do nothing
    irq_if.intr_rq = 8'hFF;
    strobe();
    strobe();
    tick(3);
    check("cfg_idle_irq", 32'(irq_if.intr_out), 32'd0);

    // polling mode, ARB ignores strobes with no requests
    irq_if.intr_rq = 8'h00;
    cpu_bus = 8'h01;
    tick(1);
    cpu_bus = 8'h00;
    strobe();
    tick(2);
    check("arb_no_req", 32'(irq_if.intr_out), 32'd0);

    irq_if.intr_rq = 8'hAA;
    for (int i = 0; i < 4; i++)
      service(3'(exp_poll[i]), 5'b01011, 5'b10100, (i == 1), 8'h00);
    irq_if.intr_rq = 8'h55;
    for (int i = 4; i < 8; i++)
      service(3'(exp_poll[i]), 5'b01011, 5'b10100, 1'b0, 8'h00);

    check("poll_count", 32'(got_ids.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_ids.size(); i++)
      check("poll_order", 32'(got_ids[i]), 32'(exp_poll[i]));
    check("model_poll_cnt", 32'(m_served.size()), 32'd8);
    for (int i = 0; i < 8 && i < m_served.size(); i++)
      check("model_poll_order", 32'(m_served[i]), 32'(exp_poll[i]));

    // reset while the vector is on the bus
    wait_irq(ok);
    if (ok) begin
      strobe();
      check("drive_oe", 32'(irq_if.bus_oe), 32'd1);
      rst_in = 1'b1;
      tick(1);
      rst_in = 1'b0;
      check("abort_oe", 32'(irq_if.bus_oe), 32'd0);
      check("abort_irq", 32'(irq_if.intr_out), 32'd0);
    end
    irq_if.intr_rq = 8'h00;

    // priority mode: four table bytes on consecutive cycles
    got_ids.delete();
    m_served.delete();
    cpu_bus = 8'hAE;
    tick(1);
    cpu_bus = 8'hE2;
    tick(1);
    cpu_bus = 8'h8A;
    tick(1);
    cpu_bus = 8'hC6;
    tick(1);
    cpu_bus = 8'h00;
    irq_if.intr_rq = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      m = 8'h01 << exp_pri[i];
      service(3'(exp_pri[i]), 5'b10011, 5'b01100, 1'b0, m);
      if (i == 4) irq_if.intr_rq = irq_if.intr_rq | 8'h08;
      if (i == 6) irq_if.intr_rq = irq_if.intr_rq | 8'h20;
    end
    check("pri_count", 32'(got_ids.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_ids.size(); i++)
      check("pri_order", 32'(got_ids[i]), 32'(exp_pri[i]));
    check("model_pri_cnt", 32'(m_served.size()), 32'd10);
    for (int i = 0; i < 10 && i < m_served.size(); i++)
      check("model_pri_order", 32'(m_served[i]), 32'(exp_pri[i]));
    tick(3);
    check("pri_all_idle", 32'(irq_if.intr_out), 32'd0);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
